// File: rtl/axis_stream_sink.sv
// AXI4-Stream packet sink: captures one packet (up to DEPTH beats) into a local
// buffer, then hands it out word by word on a pop interface. Includes a sticky stall-stability monitor.
module axis_stream_sink #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int DEPTH                = 8
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESETN,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic                              S_AXIS_TLAST,
  input  logic                              rd_en,
  output logic                              rd_valid,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   rd_data,
  output logic [C_S_AXIS_TDATA_WIDTH/8-1:0] rd_strb,
  output logic                              rd_last,
  output logic                              pkt_done,
  output logic                              overflow,
  output logic                              err_protocol,
  output logic [1:0]                        state_dbg
);

  localparam int W  = C_S_AXIS_TDATA_WIDTH;
  localparam int SW = C_S_AXIS_TDATA_WIDTH / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int MW = W + SW + 1;
  localparam logic [PW-1:0] LAST_SLOT = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RECV  = 2'b01,
    DRAIN = 2'b10
  } state_t;

  // Handshake rules on the slave port: a beat transfers on a rising edge where
  // TVALID and TREADY are both high; once TVALID is high with TREADY low, the
  // master must hold TVALID, TDATA, TSTRB and TLAST unchanged until the transfer.
  // On the pop side a word leaves on an edge where rd_en and rd_valid are both high.

  state_t          state, state_nxt;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [MW-1:0]   mem [DEPTH];
  logic [MW-1:0]   head;
  logic            beat, at_last_slot, pkt_end, pop, final_pop;
  logic            prev_stall, prev_last;
  logic [W-1:0]    prev_data;
  logic [SW-1:0]   prev_strb;

  assign S_AXIS_TREADY = (state == RECV);
  assign beat          = S_AXIS_TVALID & S_AXIS_TREADY;
  assign at_last_slot  = (wr_ptr == LAST_SLOT);
  assign pkt_end       = beat & (S_AXIS_TLAST | at_last_slot);

  assign rd_valid  = (state == DRAIN) && (rd_ptr < wr_ptr);
  assign head      = mem[rd_ptr[AW-1:0]];
  assign rd_data   = head[MW-1 -: W];
  assign rd_strb   = head[SW:1];
  assign rd_last   = head[0];
  assign pop       = rd_en & rd_valid;
  assign final_pop = pop & rd_last;
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    case (state)
      RECV:    if (pkt_end) state_nxt = DRAIN;
      DRAIN:   if (final_pop) state_nxt = IDLE;
      // IDLE, and the unused 2'b11 encoding which behaves as IDLE
      default: if (S_AXIS_TVALID) state_nxt = RECV;
    endcase
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      pkt_done     <= 1'b0;
      overflow     <= 1'b0;
      err_protocol <= 1'b0;
      prev_stall   <= 1'b0;
      prev_data    <= '0;
      prev_strb    <= '0;
      prev_last    <= 1'b0;
    end else begin
      state    <= state_nxt;
      pkt_done <= final_pop;
      if (final_pop) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (beat) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      // A full buffer without TLAST truncates; the tail arrives as a new packet.
      if (beat && !S_AXIS_TLAST && at_last_slot) overflow <= 1'b1;
      prev_stall <= S_AXIS_TVALID & ~S_AXIS_TREADY;
      prev_data  <= S_AXIS_TDATA;
      prev_strb  <= S_AXIS_TSTRB;
      prev_last  <= S_AXIS_TLAST;
      if (prev_stall && (!S_AXIS_TVALID || S_AXIS_TDATA != prev_data ||
                         S_AXIS_TSTRB != prev_strb || S_AXIS_TLAST != prev_last))
        err_protocol <= 1'b1;
    end
  end

  // Buffer contents need no reset; stored last flag is forced on a truncating beat.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (beat) mem[wr_ptr[AW-1:0]] <= {S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TLAST | at_last_slot};
  end

endmodule

// File: tb/tb_axis_stream_sink.sv
// Bench for axis_stream_sink: directed scenarios plus randomized packets, checked
// against a packet-chunking model of the sink's expected output.
module tb_axis_stream_sink;

  localparam int W     = 32;
  localparam int SW    = W / 8;
  localparam int DEPTH = 8;
  localparam int BW    = W + SW + 1;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [SW-1:0] strb;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tvalid, tready, tlast;
  logic [W-1:0]  tdata;
  logic [SW-1:0] tstrb;
  logic          rd_en, rd_valid, rd_last, pkt_done, overflow, err_protocol;
  logic [W-1:0]  rd_data;
  logic [SW-1:0] rd_strb;
  logic [1:0]    state_dbg;

  axis_stream_sink #(.C_S_AXIS_TDATA_WIDTH(W), .DEPTH(DEPTH)) dut (
    .S_AXIS_ACLK   (clk),
    .S_AXIS_ARESETN(rst_n),
    .S_AXIS_TVALID (tvalid),
    .S_AXIS_TREADY (tready),
    .S_AXIS_TDATA  (tdata),
    .S_AXIS_TSTRB  (tstrb),
    .S_AXIS_TLAST  (tlast),
    .rd_en         (rd_en),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_strb       (rd_strb),
    .rd_last       (rd_last),
    .pkt_done      (pkt_done),
    .overflow      (overflow),
    .err_protocol  (err_protocol),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int             n_checks = 0;
  int             n_pass   = 0;
  beat_t          src_q[$];
  logic [BW-1:0]  exp_q[$];
  bit             vpat[$];
  bit             rpat[$];
  int             p_valid = 100;
  int             p_rd    = 100;
  int             model_cnt = 0;
  logic           exp_ovf = 1'b0;
  logic           exp_err = 1'b0;
  int             done_cnt;
  int             ready_cycles;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Sink output model: beats are cut into chunks ending at TLAST or at DEPTH beats.
  task automatic model_push(input beat_t b);
    logic last_out;
    last_out = b.last || (model_cnt == DEPTH - 1);
    if (!b.last && model_cnt == DEPTH - 1) exp_ovf = 1'b1;
    model_cnt = last_out ? 0 : model_cnt + 1;
    exp_q.push_back({b.data, b.strb, last_out});
  endtask

  task automatic add_beat(input logic [W-1:0] d, input logic [SW-1:0] s, input logic l);
    beat_t b;
    b.data = d;
    b.strb = s;
    b.last = l;
    src_q.push_back(b);
  endtask

  task automatic model_reset();
    model_cnt = 0;
    exp_ovf   = 1'b0;
    exp_err   = 1'b0;
    exp_q.delete();
    src_q.delete();
  endtask

  // ---------------- driver / monitor engine ----------------
  // Runs on falling edges: checks outputs settled from the last rising edge, then
  // chooses the inputs for the next rising edge and predicts what it transfers.
  task automatic run(input int budget);
    bit            hs;
    bit            go;
    bit            exp_done;
    bit            finished;
    int            cyc;
    beat_t         b;
    logic [BW-1:0] e;
    hs = 0; exp_done = 0; finished = 0; cyc = 0;
    done_cnt = 0; ready_cycles = 0;
    while (!finished && cyc < budget) begin
      @(negedge clk);
      cyc++;
      check("pkt_done", 64'(pkt_done), 64'(exp_done));
      check("overflow", 64'(overflow), 64'(exp_ovf));
      check("err_protocol", 64'(err_protocol), 64'(exp_err));
      if (pkt_done) done_cnt++;
      if (tready) ready_cycles++;
      if (!tvalid || hs) begin
        tvalid = 1'b0;
        if (src_q.size() > 0) begin
          go = (vpat.size() > 0) ? vpat.pop_front() : ($urandom_range(99) < p_valid);
          if (go) begin
            tvalid = 1'b1;
            tdata  = src_q[0].data;
            tstrb  = src_q[0].strb;
            tlast  = src_q[0].last;
          end
        end
      end
      hs = tvalid & tready;
      if (hs) begin
        b = src_q.pop_front();
        model_push(b);
      end
      if (rd_valid) go = (rpat.size() > 0) ? rpat.pop_front() : ($urandom_range(99) < p_rd);
      else          go = bit'($urandom_range(1));
      rd_en = go;
      exp_done = 0;
      if (rd_en && rd_valid) begin
        if (exp_q.size() == 0) check("unexpected_pop", 64'(1), 64'(0));
        else begin
          e = exp_q.pop_front();
          check("rd_data", 64'(rd_data), 64'(e[BW-1 -: W]));
          check("rd_strb", 64'(rd_strb), 64'(e[SW:1]));
          check("rd_last", 64'(rd_last), 64'(e[0]));
          exp_done = e[0];
        end
      end
      finished = (src_q.size() == 0) && (exp_q.size() == 0) && !exp_done && !tvalid;
    end
    if (!finished) check("timeout", 64'(cyc), 64'(budget + 1));
    rd_en  = 1'b0;
    tvalid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; tvalid = 1'b0; tdata = '0; tstrb = '0; tlast = 1'b0; rd_en = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tready", 64'(tready), 64'(0));
    check("rst_rd_valid", 64'(rd_valid), 64'(0));
    check("rst_pkt_done", 64'(pkt_done), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_err", 64'(err_protocol), 64'(0));
    rst_n = 1'b1;

    // 3-beat packet, continuous valid and pop
    add_beat(32'h11, 4'hF, 1'b0);
    add_beat(32'h22, 4'hF, 1'b0);
    add_beat(32'h33, 4'hF, 1'b1);
    run(200);
    check("t1_ready_cycles", 64'(ready_cycles), 64'(3));
    check("t1_done_cnt", 64'(done_cnt), 64'(1));

    // master gaps while the sink is ready
    vpat = '{1'b1, 1'b0, 1'b1, 1'b1};
    add_beat(32'hA1, 4'h1, 1'b0);
    add_beat(32'hA2, 4'h3, 1'b0);
    add_beat(32'hA3, 4'h7, 1'b1);
    run(200);
    check("t2_done_cnt", 64'(done_cnt), 64'(1));

    // 10-beat packet truncated at DEPTH, tail follows as its own packet
    for (int i = 0; i < 10; i++) add_beat(32'h100 + i, 4'hF, i == 9);
    run(300);
    check("t3_done_cnt", 64'(done_cnt), 64'(2));
    check("t3_overflow", 64'(overflow), 64'(1));

    // pop with gaps
    rpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    add_beat(32'h1, 4'hF, 1'b0);
    add_beat(32'h2, 4'hF, 1'b0);
    add_beat(32'h3, 4'hF, 1'b1);
    run(200);
    check("t4_done_cnt", 64'(done_cnt), 64'(1));

    // randomized packets with random valid/pop throttling
    for (int p = 0; p < 8; p++) begin
      int len;
      len = $urandom_range(12, 1);
      for (int i = 0; i < len; i++)
        add_beat($urandom, SW'($urandom_range(15)), i == len - 1);
    end
    p_valid = $urandom_range(100, 60);
    p_rd    = $urandom_range(100, 40);
    run(3000);
    p_valid = 100;
    p_rd    = 100;

    // async reset after two beats of a packet
    @(negedge clk); tvalid = 1'b1; tdata = 32'hB1; tstrb = 4'hF; tlast = 1'b0;
    @(negedge clk);
    @(negedge clk); tdata = 32'hB2;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("arst_tready", 64'(tready), 64'(0));
    check("arst_rd_valid", 64'(rd_valid), 64'(0));
    tvalid = 1'b0;
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    add_beat(32'hDEADBEEF, 4'hF, 1'b1);
    run(200);
    check("t5_done_cnt", 64'(done_cnt), 64'(1));

    // stall violation: data changes while waiting for TREADY
    @(negedge clk); tvalid = 1'b1; tdata = 32'hA5; tstrb = 4'hF; tlast = 1'b1;
    @(negedge clk); tdata = 32'h5A;
    @(negedge clk);
    check("stall_err", 64'(err_protocol), 64'(1));
    tvalid = 1'b0;
    exp_err = 1'b1;
    exp_q.push_back({32'h5A, 4'hF, 1'b1});
    run(200);
    repeat (3) @(negedge clk);
    check("err_sticky", 64'(err_protocol), 64'(1));
    rst_n = 1'b0;
    @(negedge clk);
    check("err_cleared", 64'(err_protocol), 64'(0));
    rst_n = 1'b1;

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
